// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with frame/first/done strobes for back-to-back words.
// Optional macro PISO_PARITY_EN appends an even-parity bit after each word.
module piso_tx #(
  parameter int NBIT      = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NBIT-1:0] data_in,
  input  logic            load_valid,
  output logic            load_ready,
  output logic [NBIT-1:0] q,
  output logic            q_out,
  output logic            frame,
  output logic            first,
  output logic            done
);

  localparam int CW   = $clog2(NBIT + 1);
  localparam int OBIT = MSB_FIRST ? NBIT - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(NBIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]      state_q, state_d;
  logic [NBIT-1:0] sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            frame_q, frame_d;
  logic            first_q, first_d;
  logic            done_q, done_d;
  logic            q_out_q, q_out_d;
  logic            last_bit;
  logic            accept;
  logic [NBIT-1:0] shifted;

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
  assign shifted  = MSB_FIRST ? {sr_q[NBIT-2:0], 1'b0} : {1'b0, sr_q[NBIT-1:1]};

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
  // The parity cycle is the handover slot, so the next word follows without a gap.
  assign load_ready = !clr && ((state_q == IDLE) || (state_q == PARITY));
`else
  assign load_ready = !clr && ((state_q == IDLE) || last_bit);
`endif

  assign accept = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      sr_d    = data_in;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      par_d   = ^data_in;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          sr_d = shifted;
          if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
            cnt_d   = cnt_q + CW'(1);
`else
            state_d = IDLE;
            cnt_d   = '0;
`endif
            sr_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = '0;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = '0;
        end
      endcase
    end
  end

  // Strobes are computed from next state so they are clean flop outputs.
  always_comb begin
    frame_d = (state_d != IDLE);
    first_d = (state_d == SHIFT) && (cnt_d == '0);
    q_out_d = (state_d == SHIFT) ? sr_d[OBIT] : 1'b0;
`ifdef PISO_PARITY_EN
    done_d  = (state_d == PARITY);
    if (state_d == PARITY) q_out_d = par_d;
`else
    done_d  = (state_d == SHIFT) && (cnt_d == LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      q_out_q <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      first_q <= first_d;
      done_q  <= done_d;
      q_out_q <= q_out_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign q     = sr_q;
  assign q_out = q_out_q;
  assign frame = frame_q;
  assign first = first_q;
  assign done  = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one MSB-first and one LSB-first instance share stimulus.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L = 5 + PAR;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] data_in = '0;
  logic       load_valid = 1'b0;
  logic       load_ready, q_out, frame, first, done;
  logic [4:0] q;
  logic       l_load_ready, l_q_out, l_frame, l_first, l_done;
  logic [4:0] l_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_tx #(.NBIT(5), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .clr(clr), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .q(q), .q_out(q_out), .frame(frame),
    .first(first), .done(done)
  );

  piso_tx #(.NBIT(5), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clr(clr), .data_in(data_in), .load_valid(load_valid),
    .load_ready(l_load_ready), .q(l_q), .q_out(l_q_out), .frame(l_frame),
    .first(l_first), .done(l_done)
  );

  task automatic test_reset();
    clr = 1'b1; load_valid = 1'b1; data_in = 5'b11111;
    #1;
    total++;
    if (load_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", load_ready); end
    @(posedge clk); #1;
    total++;
    if ({frame, first, done, q_out, q} !== 9'b0) begin
      bad++; $display("FAIL reset_state got=%b want=%b", {frame, first, done, q_out, q}, 9'b0);
    end
    total++;
    if ({l_frame, l_q} !== 6'b0) begin bad++; $display("FAIL reset_state_lsb got=%b want=0", {l_frame, l_q}); end
    clr = 1'b0; load_valid = 1'b0;
    #1;
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", load_ready); end
    $display("reset checked");
  endtask

  task automatic test_msb_first();
    logic [5:0] exp_b;
    logic [4:0] exp_q [5];
    exp_b = 6'b101101;
    exp_q = '{5'b10110, 5'b01100, 5'b11000, 5'b10000, 5'b00000};
    data_in = 5'b10110; load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0; data_in = 5'b01010;
    for (int i = 0; i < L; i++) begin
      total++;
      if ({frame, first, done, q_out} !== {1'b1, i == 0, i == L - 1, exp_b[5 - i]}) begin
        bad++; $display("FAIL msb_bit%0d got fr/fi/dn/q=%b want=%b", i, {frame, first, done, q_out},
                        {1'b1, i == 0, i == L - 1, exp_b[5 - i]});
      end
      if (i < 5) begin
        total++;
        if (q !== exp_q[i]) begin bad++; $display("FAIL msb_q%0d got=%b want=%b", i, q, exp_q[i]); end
      end
      @(posedge clk); #1;
    end
    total++;
    if ({frame, first, done, q_out, q} !== 9'b0) begin
      bad++; $display("FAIL msb_end got=%b want=0", {frame, first, done, q_out, q});
    end
    $display("word 10110 msb-first sent");
  endtask

  task automatic test_lsb_first();
    logic [5:0] exp_b;
    logic [4:0] exp_q [5];
    exp_b = 6'b011011;
    exp_q = '{5'b10110, 5'b01011, 5'b00101, 5'b00010, 5'b00001};
    data_in = 5'b10110; load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0; data_in = 5'b11111;
    for (int i = 0; i < L; i++) begin
      total++;
      if ({l_frame, l_first, l_done, l_q_out} !== {1'b1, i == 0, i == L - 1, exp_b[5 - i]}) begin
        bad++; $display("FAIL lsb_bit%0d got fr/fi/dn/q=%b want=%b", i, {l_frame, l_first, l_done, l_q_out},
                        {1'b1, i == 0, i == L - 1, exp_b[5 - i]});
      end
      if (i < 5) begin
        total++;
        if (l_q !== exp_q[i]) begin bad++; $display("FAIL lsb_q%0d got=%b want=%b", i, l_q, exp_q[i]); end
      end
      @(posedge clk); #1;
    end
    total++;
    if ({l_frame, l_q_out, l_q} !== 7'b0) begin
      bad++; $display("FAIL lsb_end got=%b want=0", {l_frame, l_q_out, l_q});
    end
    $display("word 10110 lsb-first sent");
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_b;
`ifdef PISO_PARITY_EN
    exp_b = 12'b110011_001111;
`else
    exp_b = 12'b00_1100100111;
`endif
    data_in = 5'b11001; load_valid = 1'b1;
    @(posedge clk); #1;
    data_in = 5'b00111;
    for (int i = 0; i < 2 * L; i++) begin
      if (i == L) load_valid = 1'b0;
      #1;
      total++;
      if ({frame, first, done, q_out} !==
          {1'b1, (i == 0) || (i == L), (i == L - 1) || (i == 2 * L - 1), exp_b[2 * L - 1 - i]}) begin
        bad++; $display("FAIL b2b_bit%0d got fr/fi/dn/q=%b want=%b", i, {frame, first, done, q_out},
                        {1'b1, (i == 0) || (i == L), (i == L - 1) || (i == 2 * L - 1), exp_b[2 * L - 1 - i]});
      end
      total++;
      if (load_ready !== ((i == L - 1) || (i == 2 * L - 1))) begin
        bad++; $display("FAIL b2b_ready%0d got=%b want=%b", i, load_ready, (i == L - 1) || (i == 2 * L - 1));
      end
      @(posedge clk); #1;
    end
    total++;
    if (frame !== 1'b0) begin bad++; $display("FAIL b2b_end frame got=%b want=0", frame); end
    $display("words 11001,00111 sent back-to-back");
  endtask

  task automatic test_busy_stall();
    logic [5:0] exp_b;
    exp_b = 6'b100001;
    data_in = 5'b10000; load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (i == 1) begin
        load_valid = 1'b1; data_in = 5'b01111;
        #1;
        total++;
        if (load_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", load_ready); end
      end
      if (i == 2) load_valid = 1'b0;
      total++;
      if ({frame, done, q_out} !== {1'b1, i == L - 1, exp_b[5 - i]}) begin
        bad++; $display("FAIL stall_bit%0d got fr/dn/q=%b want=%b", i, {frame, done, q_out},
                        {1'b1, i == L - 1, exp_b[5 - i]});
      end
      @(posedge clk); #1;
    end
    total++;
    if (frame !== 1'b0) begin bad++; $display("FAIL stall_end frame got=%b want=0", frame); end
    $display("word 10000 sent, 01111 refused while busy");
  endtask

  task automatic test_reset_mid_word();
    int dones;
    bit ended;
    data_in = 5'b11111; load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({frame, done, q_out} !== 3'b101) begin
        bad++; $display("FAIL rst_bit%0d got fr/dn/q=%b want=101", i, {frame, done, q_out});
      end
      @(posedge clk); #1;
    end
    clr = 1'b1; load_valid = 1'b1; data_in = 5'b00000;
    @(posedge clk); #1;
    total++;
    if ({frame, first, done, q_out, q} !== 9'b0) begin
      bad++; $display("FAIL rst_abort got=%b want=0", {frame, first, done, q_out, q});
    end
    clr = 1'b0; data_in = 5'b10110;
    #1;
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", load_ready); end
    @(posedge clk); #1;
    load_valid = 1'b0;
    total++;
    if ({frame, first, q_out, q} !== {3'b111, 5'b10110}) begin
      bad++; $display("FAIL rst_reload got=%b want=%b", {frame, first, q_out, q}, {3'b111, 5'b10110});
    end
    dones = 0; ended = 1'b0;
    for (int c = 0; c < 20 && !ended; c++) begin
      if (done === 1'b1) dones++;
      if (frame === 1'b0) ended = 1'b1;
      else begin @(posedge clk); #1; end
    end
    total++;
    if (!ended || dones != 1) begin
      bad++; $display("FAIL rst_drain ended=%b dones=%0d want ended=1 dones=1", ended, dones);
    end
    $display("word 11111 aborted by clr, 10110 sent after");
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    data_in = 5'b10110; load_valid = 1'b1;
    @(posedge clk); #1;
    data_in = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({done, load_ready} !== 2'b00) begin
        bad++; $display("FAIL par_data%0d got dn/rdy=%b want=00", i, {done, load_ready});
      end
      @(posedge clk); #1;
    end
    total++;
    if ({frame, done, q_out, load_ready} !== 4'b1111) begin
      bad++; $display("FAIL par_bit got fr/dn/q/rdy=%b want=1111", {frame, done, q_out, load_ready});
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    total++;
    if ({frame, first, q_out, q} !== {3'b111, 5'b11111}) begin
      bad++; $display("FAIL par_b2b got=%b want=%b", {frame, first, q_out, q}, {3'b111, 5'b11111});
    end
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    total++;
    if ({frame, done, q_out} !== 3'b111) begin
      bad++; $display("FAIL par_bit2 got fr/dn/q=%b want=111", {frame, done, q_out});
    end
    @(posedge clk); #1;
    total++;
    if (frame !== 1'b0) begin bad++; $display("FAIL par_end frame got=%b want=0", frame); end
    $display("words 10110,11111 sent with parity");
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_busy_stall();
    test_reset_mid_word();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
